// File: rtl/lpc_frame_ring_ctrl_if.sv
// Bus between the frame ring controller and its clients (capture writer, frame serializer).
// slave: the ring controller itself; master: the client side driving the strobes.
interface lpc_frame_ring_ctrl_if #(
  parameter int unsigned AW     = 16,
  parameter int unsigned DROP_W = 8
);
  localparam int unsigned FW = AW - 3;

  logic [FW-1:0]     wr_frame;
  logic              wr_allow;
  logic              wr_frame_done;
  logic [FW-1:0]     target_addr;
  logic              read_empty;
  logic              read_done;
  logic              flush;
  logic [FW:0]       fill_level;
  logic              overflow;
  logic [DROP_W-1:0] drop_count;

  modport slave (
    input  wr_frame_done, read_done, flush,
    output wr_frame, wr_allow, target_addr, read_empty, fill_level, overflow, drop_count
  );

  modport master (
    output wr_frame_done, read_done, flush,
    input  wr_frame, wr_allow, target_addr, read_empty, fill_level, overflow, drop_count
  );
endinterface

// File: rtl/lpc_frame_ring_ctrl.sv
// Ring-buffer scheduler between the LPC capture writer and the frame serializer:
// tracks write/read frame pointers, hands out one frame at a time, counts overflow drops.
module lpc_frame_ring_ctrl #(
  parameter int unsigned AW     = 16,
  parameter int unsigned DROP_W = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  lpc_frame_ring_ctrl_if.slave bus
);
  localparam int unsigned FW = AW - 3;

  typedef enum logic [1:0] {IDLE, OFFER, BUSY} state_t;

  state_t            r_state, w_state_nxt;
  logic [FW:0]       r_wr_ptr, r_rd_ptr, w_wr_ptr_nxt;
  logic              r_read_empty, w_read_empty_nxt;
  logic              r_overflow, r_flush_pend;
  logic [DROP_W-1:0] r_drop_count;
  logic              w_empty, w_full, w_wr_accept, w_wr_drop, w_rd_adv, w_flush_apply;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_empty      = (r_wr_ptr == r_rd_ptr);
  assign w_full       = (r_wr_ptr[FW-1:0] == r_rd_ptr[FW-1:0]) && (r_wr_ptr[FW] != r_rd_ptr[FW]);
  assign w_wr_accept  = bus.wr_frame_done & ~w_full;
  assign w_wr_drop    = bus.wr_frame_done & w_full;
  assign w_wr_ptr_nxt = r_wr_ptr + (FW+1)'(w_wr_accept);

  // Read handshake: offer, wait for the serializer to drop done, then wait for done again.
  always_comb begin
    w_state_nxt      = r_state;
    w_read_empty_nxt = 1'b1;
    w_rd_adv         = 1'b0;
    w_flush_apply    = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_flush_pend) begin
          w_flush_apply = 1'b1;
        end else if (!w_empty) begin
          w_read_empty_nxt = 1'b0;
          w_state_nxt      = OFFER;
        end
      end
      OFFER: begin
        if (!bus.read_done) w_state_nxt = BUSY;
        else                w_read_empty_nxt = 1'b0;
      end
      BUSY: begin
        if (bus.read_done) begin
          w_rd_adv    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_read_empty <= 1'b1;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_read_empty <= w_read_empty_nxt;
      // Flush lands only between frames and also discards a write accepted this cycle.
      if (w_flush_apply)      r_rd_ptr <= w_wr_ptr_nxt;
      else if (w_rd_adv)      r_rd_ptr <= r_rd_ptr + (FW+1)'(1);
      if (w_flush_apply)      r_overflow <= 1'b0;
      else if (w_wr_drop)     r_overflow <= 1'b1;
      if (w_flush_apply)      r_drop_count <= '0;
      else if (w_wr_drop && (r_drop_count != '1))
                              r_drop_count <= r_drop_count + DROP_W'(1);
      if (bus.flush)          r_flush_pend <= 1'b1;
      else if (w_flush_apply) r_flush_pend <= 1'b0;
    end
  end

  assign bus.wr_frame    = r_wr_ptr[FW-1:0];
  assign bus.target_addr = r_rd_ptr[FW-1:0];
  assign bus.read_empty  = r_read_empty;
  assign bus.wr_allow    = ~w_full;
  assign bus.fill_level  = r_wr_ptr - r_rd_ptr;
  assign bus.overflow    = r_overflow;
  assign bus.drop_count  = r_drop_count;
endmodule
